// File: rtl/alu_op_sequencer_if.sv
// Request/result bus of the ALU op sequencer.
// The decode side drives an op with a valid/ready handshake.
// The writeback side consumes the result with a second valid/ready handshake.
interface alu_op_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic             isArith;
  logic             isTwoC;
  logic             LeftOrRight;
  logic [1:0]       Operation;
  logic [2:0]       SetFlag;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] result;
  logic             carry_flag;
  logic             zero_flag;
  logic             sign_flag;
  logic             busy;

  modport master (
    output req_valid, isArith, isTwoC, LeftOrRight, Operation, SetFlag, op_a, op_b, res_ready,
    input  req_ready, res_valid, result, carry_flag, zero_flag, sign_flag, busy
  );

  modport slave (
    input  req_valid, isArith, isTwoC, LeftOrRight, Operation, SetFlag, op_a, op_b, res_ready,
    output req_ready, res_valid, result, carry_flag, zero_flag, sign_flag, busy
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU execution controller.
// ADD/SUB/AND/XOR complete in one cycle.
// Shifts iterate one bit per cycle.
// C/Z/S flags are written on entry to DONE, masked by SetFlag.
module alu_op_sequencer #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input logic     clk,
  input logic     rst,
  input logic     flush,
  alu_op_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } stateT;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_AND   = 2'b01;
  localparam logic [1:0] OP_XOR   = 2'b10;
  localparam logic [1:0] OP_SHIFT = 2'b11;

  stateT            stateR, nextStateS;
  logic [WIDTH-1:0] accR;
  logic [SHW-1:0]   countR;
  logic             arithR, leftR;
  logic [2:0]       setFlagR;
  logic [WIDTH-1:0] resultR;
  logic             carryR, zeroR, signR;
  logic             resValidR, reqReadyR, busyR;

  logic             acceptS;
  logic [SHW-1:0]   shamtS;
  logic [WIDTH-1:0] aluResS, shiftAccS, doneResS;
  logic             aluCarryS, shiftOutS, doneCarryS, writeDoneS;
  logic [2:0]       doneSetFlagS;

  // WIDTH+1-bit add so the top bit is the carry-out; SUB is a + ~b + 1
  function automatic logic [WIDTH:0] addWithCarry(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic             sub);
    logic [WIDTH-1:0] bOp;
    bOp = sub ? ~b : b;
    return {1'b0, a} + {1'b0, bOp} + {{WIDTH{1'b0}}, sub};
  endfunction

  assign acceptS = (stateR == IDLE) && bus.req_valid;
  assign shamtS  = bus.op_b[SHW-1:0];

  // Single-cycle result and carry computed from the request fields at accept
  always_comb begin
    aluResS   = {WIDTH{1'b0}};
    aluCarryS = 1'b0;
    case (bus.Operation)
      OP_ADD:   {aluCarryS, aluResS} = addWithCarry(bus.op_a, bus.op_b, bus.isTwoC);
      OP_AND:   aluResS = bus.op_a & bus.op_b;
      OP_XOR:   aluResS = bus.op_a ^ bus.op_b;
      OP_SHIFT: aluResS = bus.op_a;  // only reached with shamt==0, C stays 0
      default:  aluResS = {WIDTH{1'b0}};
    endcase
  end

  // One-bit shift step of the accumulator and the bit that falls out
  always_comb begin
    shiftAccS = accR;
    shiftOutS = 1'b0;
    if (leftR) begin
      shiftAccS = {accR[WIDTH-2:0], 1'b0};
      shiftOutS = accR[WIDTH-1];
    end else begin
      shiftAccS = {(arithR ? accR[WIDTH-1] : 1'b0), accR[WIDTH-1:1]};
      shiftOutS = accR[0];
    end
  end

  // Next-state decode plus the value/flags to commit on entry to DONE
  always_comb begin
    nextStateS   = stateR;
    writeDoneS   = 1'b0;
    doneResS     = {WIDTH{1'b0}};
    doneCarryS   = 1'b0;
    doneSetFlagS = 3'b000;
    if (flush) begin
      nextStateS = IDLE;
    end else begin
      case (stateR)
        IDLE: begin
          if (acceptS) begin
            if ((bus.Operation == OP_SHIFT) && (shamtS != {SHW{1'b0}})) begin
              nextStateS = SHIFT;
            end else begin
              nextStateS   = DONE;
              writeDoneS   = 1'b1;
              doneResS     = aluResS;
              doneCarryS   = aluCarryS;
              doneSetFlagS = bus.SetFlag;
            end
          end else begin
            nextStateS = IDLE;
          end
        end
        SHIFT: begin
          if (countR == SHW'(1)) begin
            nextStateS   = DONE;
            writeDoneS   = 1'b1;
            doneResS     = shiftAccS;
            doneCarryS   = shiftOutS;
            doneSetFlagS = setFlagR;
          end else begin
            nextStateS = SHIFT;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            nextStateS = IDLE;
          end else begin
            nextStateS = DONE;
          end
        end
        default: nextStateS = IDLE;
      endcase
    end
  end

  // State register and registered handshake/status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateR    <= IDLE;
      resValidR <= 1'b0;
      reqReadyR <= 1'b1;
      busyR     <= 1'b0;
    end else begin
      stateR    <= nextStateS;
      resValidR <= (nextStateS == DONE);
      reqReadyR <= (nextStateS == IDLE);
      busyR     <= (nextStateS != IDLE);
    end
  end

  // Operand capture at accept and iterative shift accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accR     <= {WIDTH{1'b0}};
      countR   <= {SHW{1'b0}};
      arithR   <= 1'b0;
      leftR    <= 1'b0;
      setFlagR <= 3'b000;
    end else if (!flush) begin
      if (acceptS) begin
        accR     <= bus.op_a;
        countR   <= shamtS;
        arithR   <= bus.isArith;
        leftR    <= bus.LeftOrRight;
        setFlagR <= bus.SetFlag;
      end else if (stateR == SHIFT) begin
        accR   <= shiftAccS;
        countR <= countR - SHW'(1);
      end
    end
  end

  // Result and architectural flags, written only when entering DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resultR <= {WIDTH{1'b0}};
      carryR  <= 1'b0;
      zeroR   <= 1'b0;
      signR   <= 1'b0;
    end else if (writeDoneS) begin
      resultR <= doneResS;
      if (doneSetFlagS[0]) carryR <= doneCarryS;
      if (doneSetFlagS[1]) zeroR  <= (doneResS == {WIDTH{1'b0}});
      if (doneSetFlagS[2]) signR  <= doneResS[WIDTH-1];
    end
  end

  assign bus.req_ready  = reqReadyR;
  assign bus.res_valid  = resValidR;
  assign bus.result     = resultR;
  assign bus.carry_flag = carryR;
  assign bus.zero_flag  = zeroR;
  assign bus.sign_flag  = signR;
  assign bus.busy       = busyR;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: expected results are queued at
// drive time from a behavioural model and popped when res_valid appears.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  alu_op_if #(.WIDTH(32)) bus ();

  alu_op_sequencer #(.WIDTH(32), .SHW(5)) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        z;
    logic        s;
    logic [7:0]  lat;
  } expT;

  expT  expQ[$];
  int   errCount = 0;
  int   checkCount = 0;
  logic mC = 1'b0, mZ = 1'b0, mS = 1'b0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Behavioural reference using whole-word operators
  function automatic void refOp(input logic [1:0] op, input logic twoC, input logic arith,
                                input logic lr, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic c);
    int k;
    logic [32:0] wide;
    k = int'(b[4:0]);
    r = 32'h0;
    c = 1'b0;
    case (op)
      2'b00: begin
        if (twoC) begin
          r = a - b;
          c = (a >= b);
        end else begin
          wide = {1'b0, a} + {1'b0, b};
          r = wide[31:0];
          c = wide[32];
        end
      end
      2'b01: r = a & b;
      2'b10: r = a ^ b;
      default: begin
        if (k == 0) begin
          r = a;
        end else if (lr) begin
          r = a << k;
          c = a[32-k];
        end else begin
          r = arith ? 32'($signed(a) >>> k) : (a >> k);
          c = a[k-1];
        end
      end
    endcase
  endfunction

  task automatic runOp(input string tag, input logic [1:0] op, input logic twoC,
                       input logic arith, input logic lr, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] sf, input int hold);
    logic [31:0] r;
    logic        c;
    expT         e;
    int          cyc;
    refOp(op, twoC, arith, lr, a, b, r, c);
    if (sf[0]) mC = c;
    if (sf[1]) mZ = (r == 32'h0);
    if (sf[2]) mS = r[31];
    e.res = r; e.c = mC; e.z = mZ; e.s = mS;
    e.lat = ((op == 2'b11) && (b[4:0] != 5'd0)) ? 8'(b[4:0]) + 8'd1 : 8'd1;
    expQ.push_back(e);
    checkVal({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.Operation = op; bus.isTwoC = twoC; bus.isArith = arith;
    bus.LeftOrRight = lr; bus.op_a = a; bus.op_b = b; bus.SetFlag = sf;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.op_a = 32'hDEAD_BEEF; bus.op_b = 32'h1234_5678; bus.SetFlag = 3'b000;
    cyc = 1;
    while (!bus.res_valid && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    e = expQ.pop_front();
    if (!bus.res_valid) begin
      checkVal({tag, ".timeout"}, 32'd0, 32'd1);
    end else begin
      checkVal({tag, ".result"}, bus.result, e.res);
      checkVal({tag, ".C"}, 32'(bus.carry_flag), 32'(e.c));
      checkVal({tag, ".Z"}, 32'(bus.zero_flag), 32'(e.z));
      checkVal({tag, ".S"}, 32'(bus.sign_flag), 32'(e.s));
      checkVal({tag, ".latency"}, 32'(cyc), 32'(e.lat));
      checkVal({tag, ".busy"}, 32'(bus.busy), 32'd1);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        checkVal({tag, ".hold.result"}, bus.result, e.res);
        checkVal({tag, ".hold.res_valid"}, 32'(bus.res_valid), 32'd1);
        checkVal({tag, ".hold.req_ready"}, 32'(bus.req_ready), 32'd0);
      end
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      checkVal({tag, ".drain.res_valid"}, 32'(bus.res_valid), 32'd0);
      checkVal({tag, ".drain.req_ready"}, 32'(bus.req_ready), 32'd1);
    end
  endtask

  task automatic checkFlags(input string tag);
    checkVal({tag, ".C"}, 32'(bus.carry_flag), 32'(mC));
    checkVal({tag, ".Z"}, 32'(bus.zero_flag), 32'(mZ));
    checkVal({tag, ".S"}, 32'(bus.sign_flag), 32'(mS));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkVal({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
    checkVal({tag, ".res_valid"}, 32'(bus.res_valid), 32'd0);
    checkVal({tag, ".busy"}, 32'(bus.busy), 32'd0);
    checkVal({tag, ".result"}, bus.result, 32'h0);
    checkVal({tag, ".flags"}, {29'd0, bus.sign_flag, bus.zero_flag, bus.carry_flag}, 32'd0);
  endtask

  task automatic startLongShift();
    bus.req_valid = 1'b1; bus.Operation = 2'b11; bus.isArith = 1'b0; bus.LeftOrRight = 1'b0;
    bus.op_a = 32'hFFFF_FFFF; bus.op_b = 32'd31; bus.SetFlag = 3'b111;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  initial begin
    logic sawValid;
    bus.req_valid = 1'b0; bus.res_ready = 1'b0; bus.isArith = 1'b0; bus.isTwoC = 1'b0;
    bus.LeftOrRight = 1'b0; bus.Operation = 2'b00; bus.SetFlag = 3'b000;
    bus.op_a = 32'h0; bus.op_b = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    runOp("add_wrap", 2'b00, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1, 3'b111, 0);
    runOp("sub_borrow", 2'b00, 1'b1, 1'b0, 1'b0, 32'h5, 32'h7, 3'b111, 0);
    runOp("asr4", 2'b11, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'h4, 3'b111, 0);
    runOp("shl1", 2'b11, 1'b0, 1'b0, 1'b1, 32'hC000_0001, 32'h1, 3'b111, 0);
    runOp("and_zonly", 2'b01, 1'b0, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 3'b010, 0);
    runOp("xor_hold3", 2'b10, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'hFFFF_0000, 3'b111, 3);
    runOp("shift0", 2'b11, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001, 32'h20, 3'b111, 0);
    runOp("lsr31", 2'b11, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'd31, 3'b111, 1);

    for (int i = 0; i < 8; i++) begin
      runOp($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(),
            {27'd0, 5'($urandom_range(0, 31))}, 3'($urandom_range(0, 7)), i % 2);
    end

    // Flush mid-shift: op discarded, no result, flags untouched
    startLongShift();
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkVal("flush.res_valid", 32'(bus.res_valid), 32'd0);
    checkVal("flush.req_ready", 32'(bus.req_ready), 32'd1);
    checkVal("flush.busy", 32'(bus.busy), 32'd0);
    sawValid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.res_valid) sawValid = 1'b1;
    end
    checkVal("flush.no_result", 32'(sawValid), 32'd0);
    checkFlags("flush.flags");

    runOp("after_flush", 2'b00, 1'b0, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'h1, 3'b111, 0);

    // Async reset mid-shift: outputs return to reset values without a clock edge
    startLongShift();
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkResetOutputs("async_rst");
    mC = 1'b0; mZ = 1'b0; mS = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    runOp("after_rst", 2'b00, 1'b1, 1'b0, 1'b0, 32'h9, 32'h9, 3'b111, 0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
